// File: rtl/l1b_buyruk_yanitlayici.sv
// Fetch responder: forwards stage-1 fetch addresses to instruction memory and
// buffers in-order responses for stage 2, with credit-based flow control.
module l1b_buyruk_yanitlayici #(
  parameter int unsigned DERINLIK = 4,
  parameter int unsigned PS_BIT   = 32,
  parameter int unsigned VERI_BIT = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [PS_BIT-1:0]           g1_istek_ps_i,
  input  logic                        g1_istek_gecerli_i,
  output logic                        g1_istek_hazir_o,
  output logic [PS_BIT-1:0]           bellek_istek_ps_o,
  output logic                        bellek_istek_gecerli_o,
  input  logic                        bellek_istek_hazir_i,
  input  logic [VERI_BIT-1:0]         bellek_yanit_veri_i,
  input  logic                        bellek_yanit_gecerli_i,
  output logic [VERI_BIT-1:0]         g2_buyruk_o,
  output logic                        g2_buyruk_gecerli_o,
  input  logic                        g2_buyruk_hazir_i,
  output logic [$clog2(DERINLIK):0]   bekleyen_o,
  output logic                        hata_o
);

  localparam int unsigned AW = $clog2(DERINLIK);
  localparam int unsigned CW = AW + 1;

  logic [VERI_BIT-1:0] tampon_q [DERINLIK];
  logic [AW-1:0]       yaz_ptr_q, yaz_ptr_d;
  logic [AW-1:0]       oku_ptr_q, oku_ptr_d;
  logic [CW-1:0]       bekleyen_q, bekleyen_d;
  logic [CW-1:0]       doluluk_q, doluluk_d;
  logic                hata_q, hata_d;

  logic [CW-1:0] kredi;
  logic          kredi_var;
  logic          istek, yanit, tuketim, bos;

  // Credit uses registered state only, so hazir never depends on this cycle's
  // consume and no combinational path exists from g2 or g1 valid to g1 ready.
  assign kredi     = CW'(DERINLIK) - bekleyen_q - doluluk_q;
  assign kredi_var = (kredi != '0);
  assign bos       = (doluluk_q == '0);

  assign bellek_istek_ps_o      = g1_istek_ps_i;
  assign bellek_istek_gecerli_o = g1_istek_gecerli_i & kredi_var;
  assign g1_istek_hazir_o       = bellek_istek_hazir_i & kredi_var;

  assign istek   = g1_istek_gecerli_i & g1_istek_hazir_o;
  assign yanit   = bellek_yanit_gecerli_i & (bekleyen_q != '0);
  assign tuketim = ~bos & g2_buyruk_hazir_i;

  assign g2_buyruk_gecerli_o = ~bos;
  assign g2_buyruk_o         = bos ? '0 : tampon_q[oku_ptr_q];
  assign bekleyen_o          = bekleyen_q;
  assign hata_o              = hata_q;

  always_comb begin
    yaz_ptr_d  = yaz_ptr_q + AW'(yanit);
    oku_ptr_d  = oku_ptr_q + AW'(tuketim);
    bekleyen_d = bekleyen_q + CW'(istek) - CW'(yanit);
    doluluk_d  = doluluk_q + CW'(yanit) - CW'(tuketim);
    hata_d     = hata_q | (bellek_yanit_gecerli_i & (bekleyen_q == '0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      yaz_ptr_q  <= '0;
      oku_ptr_q  <= '0;
      bekleyen_q <= '0;
      doluluk_q  <= '0;
      hata_q     <= 1'b0;
    end else begin
      yaz_ptr_q  <= yaz_ptr_d;
      oku_ptr_q  <= oku_ptr_d;
      bekleyen_q <= bekleyen_d;
      doluluk_q  <= doluluk_d;
      hata_q     <= hata_d;
    end
  end

  // Storage needs no reset: the head is only presented while doluluk is non-zero.
  always_ff @(posedge clk_i) begin
    if (!rst_i && yanit) begin
      tampon_q[yaz_ptr_q] <= bellek_yanit_veri_i;
    end
  end

endmodule

// File: tb/tb_l1b_buyruk_yanitlayici.sv
// Directed bench for l1b_buyruk_yanitlayici with hand-computed expectations.
module tb_l1b_buyruk_yanitlayici;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] g1_istek_ps_i;
  logic        g1_istek_gecerli_i;
  logic        g1_istek_hazir_o;
  logic [31:0] bellek_istek_ps_o;
  logic        bellek_istek_gecerli_o;
  logic        bellek_istek_hazir_i;
  logic [31:0] bellek_yanit_veri_i;
  logic        bellek_yanit_gecerli_i;
  logic [31:0] g2_buyruk_o;
  logic        g2_buyruk_gecerli_o;
  logic        g2_buyruk_hazir_i;
  logic [2:0]  bekleyen_o;
  logic        hata_o;

  int gecen  = 0;
  int toplam = 0;

  l1b_buyruk_yanitlayici #(
    .DERINLIK (4),
    .PS_BIT   (32),
    .VERI_BIT (32)
  ) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .g1_istek_ps_i          (g1_istek_ps_i),
    .g1_istek_gecerli_i     (g1_istek_gecerli_i),
    .g1_istek_hazir_o       (g1_istek_hazir_o),
    .bellek_istek_ps_o      (bellek_istek_ps_o),
    .bellek_istek_gecerli_o (bellek_istek_gecerli_o),
    .bellek_istek_hazir_i   (bellek_istek_hazir_i),
    .bellek_yanit_veri_i    (bellek_yanit_veri_i),
    .bellek_yanit_gecerli_i (bellek_yanit_gecerli_i),
    .g2_buyruk_o            (g2_buyruk_o),
    .g2_buyruk_gecerli_o    (g2_buyruk_gecerli_o),
    .g2_buyruk_hazir_i      (g2_buyruk_hazir_i),
    .bekleyen_o             (bekleyen_o),
    .hata_o                 (hata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    toplam++;
    if (gozlenen === beklenen) gecen++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", etiket, gozlenen, beklenen);
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow a further #1.
  task automatic saat();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bosalt_girisler();
    g1_istek_gecerli_i     = 1'b0;
    bellek_yanit_gecerli_i = 1'b0;
    g2_buyruk_hazir_i      = 1'b0;
  endtask

  logic [31:0] kuyruk[$];
  int          gonderilen;
  int          alinan;
  logic        kabul;

  initial begin
    rst_i                  = 1'b1;
    g1_istek_ps_i          = '0;
    g1_istek_gecerli_i     = 1'b0;
    bellek_istek_hazir_i   = 1'b0;
    bellek_yanit_veri_i    = '0;
    bellek_yanit_gecerli_i = 1'b0;
    g2_buyruk_hazir_i      = 1'b0;
    saat();
    saat();
    rst_i = 1'b0;
    #1;
    kontrol("rst_gecerli", 32'(g2_buyruk_gecerli_o), 32'd0);
    kontrol("rst_buyruk", g2_buyruk_o, 32'h0);
    kontrol("rst_bekleyen", 32'(bekleyen_o), 32'd0);
    kontrol("rst_hata", 32'(hata_o), 32'd0);

    // Single fetch, memory latency 2
    saat();
    g1_istek_ps_i        = 32'h8000_0000;
    g1_istek_gecerli_i   = 1'b1;
    bellek_istek_hazir_i = 1'b1;
    #1;
    kontrol("tek_hazir", 32'(g1_istek_hazir_o), 32'd1);
    kontrol("tek_mem_gecerli", 32'(bellek_istek_gecerli_o), 32'd1);
    kontrol("tek_mem_ps", bellek_istek_ps_o, 32'h8000_0000);
    saat();
    g1_istek_gecerli_i = 1'b0;
    #1;
    kontrol("tek_bekleyen1", 32'(bekleyen_o), 32'd1);
    saat();
    bellek_yanit_veri_i    = 32'h0000_0013;
    bellek_yanit_gecerli_i = 1'b1;
    #1;
    kontrol("tek_bypass_yok", 32'(g2_buyruk_gecerli_o), 32'd0);
    saat();
    bellek_yanit_gecerli_i = 1'b0;
    #1;
    kontrol("tek_gecerli", 32'(g2_buyruk_gecerli_o), 32'd1);
    kontrol("tek_buyruk", g2_buyruk_o, 32'h0000_0013);
    kontrol("tek_bekleyen0", 32'(bekleyen_o), 32'd0);
    g2_buyruk_hazir_i = 1'b1;
    saat();
    g2_buyruk_hazir_i = 1'b0;
    #1;
    kontrol("tek_tuketildi", 32'(g2_buyruk_gecerli_o), 32'd0);

    // Credit stall
    for (int i = 0; i < 4; i++) begin
      g1_istek_ps_i      = 32'h100 + 32'(i) * 4;
      g1_istek_gecerli_i = 1'b1;
      #1;
      kontrol("kredi_hazir", 32'(g1_istek_hazir_o), 32'd1);
      saat();
    end
    g1_istek_gecerli_i = 1'b0;
    #1;
    kontrol("kredi_bekleyen4", 32'(bekleyen_o), 32'd4);
    kontrol("kredi_yok", 32'(g1_istek_hazir_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bellek_yanit_veri_i    = 32'hA0 + 32'(i);
      bellek_yanit_gecerli_i = 1'b1;
      saat();
    end
    bellek_yanit_gecerli_i = 1'b0;
    #1;
    kontrol("dolu_bekleyen0", 32'(bekleyen_o), 32'd0);
    kontrol("dolu_hazir0", 32'(g1_istek_hazir_o), 32'd0);
    kontrol("dolu_bas", g2_buyruk_o, 32'hA0);
    g2_buyruk_hazir_i = 1'b1;
    #1;
    kontrol("tuketim_ayni_cevrim", 32'(g1_istek_hazir_o), 32'd0);
    saat();
    g2_buyruk_hazir_i = 1'b0;
    #1;
    kontrol("tuketim_sonrasi_hazir", 32'(g1_istek_hazir_o), 32'd1);
    kontrol("tuketim_bas", g2_buyruk_o, 32'hA1);
    saat();
    kontrol("bekle_sabit", g2_buyruk_o, 32'hA1);
    g2_buyruk_hazir_i = 1'b1;
    saat();
    kontrol("bosalt_A2", g2_buyruk_o, 32'hA2);
    saat();
    kontrol("bosalt_A3", g2_buyruk_o, 32'hA3);
    saat();
    g2_buyruk_hazir_i = 1'b0;
    #1;
    kontrol("bosalt_bos", 32'(g2_buyruk_gecerli_o), 32'd0);

    // In-order wrap: 10 requests, latency 1, response word = address
    gonderilen        = 0;
    alinan            = 0;
    g2_buyruk_hazir_i = 1'b1;
    for (int c = 0; c < 40 && alinan < 10; c++) begin
      g1_istek_gecerli_i = (gonderilen < 10);
      g1_istek_ps_i      = 32'(gonderilen) * 4;
      if (kuyruk.size() > 0) begin
        bellek_yanit_gecerli_i = 1'b1;
        bellek_yanit_veri_i    = kuyruk.pop_front();
      end else begin
        bellek_yanit_gecerli_i = 1'b0;
      end
      #1;
      kabul = g1_istek_gecerli_i & g1_istek_hazir_o;
      if (g2_buyruk_gecerli_o) begin
        kontrol("sira", g2_buyruk_o, 32'(alinan) * 4);
        alinan++;
      end
      saat();
      if (kabul) begin
        kuyruk.push_back(g1_istek_ps_i);
        gonderilen++;
      end
    end
    kontrol("sira_adet", 32'(alinan), 32'd10);
    bosalt_girisler();
    #1;
    kontrol("sira_bekleyen0", 32'(bekleyen_o), 32'd0);

    // Simultaneous istek + yanit + consume with doluluk=2, bekleyen=1
    for (int i = 0; i < 3; i++) begin
      g1_istek_ps_i      = 32'h200 + 32'(i) * 4;
      g1_istek_gecerli_i = 1'b1;
      saat();
    end
    g1_istek_gecerli_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bellek_yanit_veri_i    = 32'hB0 + 32'(i);
      bellek_yanit_gecerli_i = 1'b1;
      saat();
    end
    #1;
    kontrol("es_once_bekleyen", 32'(bekleyen_o), 32'd1);
    g1_istek_gecerli_i  = 1'b1;
    bellek_yanit_veri_i = 32'hB2;
    g2_buyruk_hazir_i   = 1'b1;
    #1;
    kontrol("es_istek_hazir", 32'(g1_istek_hazir_o), 32'd1);
    saat();
    bosalt_girisler();
    #1;
    kontrol("es_bekleyen", 32'(bekleyen_o), 32'd1);
    kontrol("es_bas", g2_buyruk_o, 32'hB1);
    g2_buyruk_hazir_i = 1'b1;
    saat();
    kontrol("es_ikinci", g2_buyruk_o, 32'hB2);
    saat();
    kontrol("es_doluluk2", 32'(g2_buyruk_gecerli_o), 32'd0);
    g2_buyruk_hazir_i      = 1'b0;
    bellek_yanit_veri_i    = 32'hB3;
    bellek_yanit_gecerli_i = 1'b1;
    saat();
    bellek_yanit_gecerli_i = 1'b0;
    g2_buyruk_hazir_i      = 1'b1;
    saat();
    g2_buyruk_hazir_i = 1'b0;
    #1;
    kontrol("es_temiz", 32'(bekleyen_o), 32'd0);

    // Memory backpressure
    bellek_istek_hazir_i = 1'b0;
    g1_istek_ps_i        = 32'h0000_1234;
    g1_istek_gecerli_i   = 1'b1;
    #1;
    kontrol("geri_hazir", 32'(g1_istek_hazir_o), 32'd0);
    kontrol("geri_mem_gecerli", 32'(bellek_istek_gecerli_o), 32'd1);
    kontrol("geri_ps", bellek_istek_ps_o, 32'h0000_1234);
    saat();
    kontrol("geri_bekleyen", 32'(bekleyen_o), 32'd0);
    g1_istek_gecerli_i   = 1'b0;
    bellek_istek_hazir_i = 1'b1;

    // Protocol error and reset
    bellek_yanit_veri_i    = 32'hDEAD_BEEF;
    bellek_yanit_gecerli_i = 1'b1;
    saat();
    bellek_yanit_gecerli_i = 1'b0;
    #1;
    kontrol("hata_set", 32'(hata_o), 32'd1);
    kontrol("hata_atildi", 32'(g2_buyruk_gecerli_o), 32'd0);
    kontrol("hata_bekleyen", 32'(bekleyen_o), 32'd0);
    saat();
    kontrol("hata_tutulur", 32'(hata_o), 32'd1);
    rst_i = 1'b1;
    saat();
    rst_i = 1'b0;
    #1;
    kontrol("rst2_hata", 32'(hata_o), 32'd0);
    kontrol("rst2_gecerli", 32'(g2_buyruk_gecerli_o), 32'd0);
    kontrol("rst2_bekleyen", 32'(bekleyen_o), 32'd0);

    // Reset with a request in flight, then its late response
    g1_istek_gecerli_i = 1'b1;
    saat();
    g1_istek_gecerli_i = 1'b0;
    #1;
    kontrol("ucus_bekleyen", 32'(bekleyen_o), 32'd1);
    rst_i = 1'b1;
    saat();
    rst_i = 1'b0;
    #1;
    kontrol("ucus_rst_bekleyen", 32'(bekleyen_o), 32'd0);
    bellek_yanit_gecerli_i = 1'b1;
    saat();
    bellek_yanit_gecerli_i = 1'b0;
    #1;
    kontrol("ucus_gec_yanit_hata", 32'(hata_o), 32'd1);
    kontrol("ucus_gec_yanit_bos", 32'(g2_buyruk_gecerli_o), 32'd0);

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule
